fsm_trace_monitor: RTL

- Synthesizable reader/checker for the state-code stream `y` of the multi-state ring FSM.
- Holds a golden next-state model, samples `y` every cycle, flags divergence and counts errors, ring laps and run cycles.
- Sits beside the FSM under test in hardware and sim harnesses. Replaces printf-style checking with on-chip `error`/`done` flags.

---
 rtl/fsm_mon_pkg.sv | 29 ++
 rtl/fsm_ring_model.sv | 38 +++
 rtl/fsm_trace_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fsm_mon_pkg.sv
// rtl/fsm_mon_pkg.sv - shared types, defaults and helpers for the FSM trace monitor
// Contents:
//   ctrl_state_e : monitor control states IDLE, SYNC, TRACK, DONE, FAIL
//   DEF_*        : default parameter values
//   sat_inc      : increment that sticks at the all-ones value of a w-bit counter
package fsm_mon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    TRACK = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } ctrl_state_e;

  localparam int DEF_NUM_STATES   = 15;
  localparam int DEF_STATE_W      = 4;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_RUN_CYCLES   = 20;
  localparam int DEF_SYNC_TIMEOUT = 15;

  // The counter value travels zero-extended to 32 bits and w gives its real width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fsm_ring_model.sv
// rtl/fsm_ring_model.sv - combinational golden next-state function of the ring FSM
// Ports:
//   s_i      in  STATE_W     current state code
//   guard_i  in  NUM_STATES  per-state advance condition
//   next_o   out STATE_W     guard[s] ? (s==NUM_STATES-1 ? 0 : s+1) : s
//   wrap_o   out 1           transition is the NUM_STATES-1 -> 0 wrap
module fsm_ring_model
  import fsm_mon_pkg::*;
#(
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int STATE_W    = DEF_STATE_W
) (
  input  logic [STATE_W-1:0]    s_i,
  input  logic [NUM_STATES-1:0] guard_i,
  output logic [STATE_W-1:0]    next_o,
  output logic                  wrap_o
);

  logic adv;

  always_comb begin
    // Decoded select keeps illegal codes (>= NUM_STATES) from indexing past guard_i;
    // they never advance.
    adv = 1'b0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (s_i == STATE_W'(i)) adv = guard_i[i];
    end
    wrap_o = adv && (s_i == STATE_W'(NUM_STATES - 1));
    if (!adv) begin
      next_o = s_i;
    end else if (wrap_o) begin
      next_o = '0;
    end else begin
      next_o = s_i + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_trace_monitor.sv
// rtl/fsm_trace_monitor.sv - on-chip checker of the ring FSM state-code stream
// Optional build macro: FSM_MON_STOP_ON_ERROR_EN (first TRACK mismatch goes to FAIL).
// Ports:
//   clock      in  1           rising-edge clock
//   reset      in  1           asynchronous active-high reset
//   en         in  1           run enable
//   guard      in  NUM_STATES  per-state advance condition
//   y          in  STATE_W     observed state code
//   expected   out STATE_W     predicted code for the current cycle
//   mismatch   out 1           one-cycle pulse, registered, after a divergent sample
//   error      out 1           sticky error
//   err_count  out CNT_W       saturating mismatch count
//   laps       out CNT_W       saturating completed-ring count
//   cycles     out CNT_W       TRACK cycles elapsed
//   busy       out 1           in SYNC or TRACK
//   done       out 1           in DONE
module fsm_trace_monitor
  import fsm_mon_pkg::*;
#(
  parameter int NUM_STATES   = DEF_NUM_STATES,
  parameter int STATE_W      = DEF_STATE_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int RUN_CYCLES   = DEF_RUN_CYCLES,
  parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_STATES-1:0] guard,
  input  logic [STATE_W-1:0]    y,
  output logic [STATE_W-1:0]    expected,
  output logic                  mismatch,
  output logic                  error,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      laps,
  output logic [CNT_W-1:0]      cycles,
  output logic                  busy,
  output logic                  done
);

`ifdef FSM_MON_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERROR = 1'b1;
`else
  localparam bit STOP_ON_ERROR = 1'b0;
`endif

  ctrl_state_e          state_q, state_d;
  logic [STATE_W-1:0]   expected_q, expected_d;
  logic                 mismatch_q, mismatch_d;
  logic                 error_q, error_d;
  logic [CNT_W-1:0]     err_count_q, err_count_d;
  logic [CNT_W-1:0]     laps_q, laps_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic [CNT_W-1:0]     timer_q, timer_d;

  logic [STATE_W-1:0]   model_next;
  logic                 model_wrap;
  logic                 y_illegal;
  logic                 y_diverges;

  // One model instance on y covers both uses: in SYNC the hand-off happens only
  // when y==0, so next(y) there is next(0).
  fsm_ring_model #(
    .NUM_STATES(NUM_STATES),
    .STATE_W   (STATE_W)
  ) u_model (
    .s_i    (y),
    .guard_i(guard),
    .next_o (model_next),
    .wrap_o (model_wrap)
  );

  assign y_illegal  = (32'(y) >= 32'(NUM_STATES));
  assign y_diverges = (y != expected_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      mismatch_q  <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      laps_q      <= '0;
      cycles_q    <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      mismatch_q  <= mismatch_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
      laps_q      <= laps_d;
      cycles_q    <= cycles_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    mismatch_d  = 1'b0;
    error_d     = error_q;
    err_count_d = err_count_q;
    laps_d      = laps_q;
    cycles_d    = cycles_q;
    timer_d     = timer_q;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d     = SYNC;
          err_count_d = '0;
          laps_d      = '0;
          cycles_d    = '0;
          error_d     = 1'b0;
          timer_d     = '0;
        end
      end

      SYNC: begin
        if (y == '0) begin
          state_d    = TRACK;
          expected_d = model_next;
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_q == CNT_W'(SYNC_TIMEOUT - 1)) begin
            state_d = FAIL;
            error_d = 1'b1;
          end else if (!en) begin
            state_d = IDLE;
          end
        end
      end

      TRACK: begin
        if (y_illegal) begin
          mismatch_d  = 1'b1;
          error_d     = 1'b1;
          err_count_d = CNT_W'(sat_inc(32'(err_count_q), CNT_W));
          state_d     = FAIL;
        end else begin
          if (y_diverges) begin
            mismatch_d  = 1'b1;
            error_d     = 1'b1;
            err_count_d = CNT_W'(sat_inc(32'(err_count_q), CNT_W));
          end else if (model_wrap) begin
            laps_d = CNT_W'(sat_inc(32'(laps_q), CNT_W));
          end

          if (STOP_ON_ERROR && y_diverges) begin
            state_d = FAIL;
          end else begin
            // Resync on divergence: predict from what was actually seen.
            expected_d = model_next;
            // The final TRACK cycle is not added to cycles, so a full run reads RUN_CYCLES-1.
            if (cycles_q == CNT_W'(RUN_CYCLES - 1)) begin
              state_d = DONE;
            end else begin
              cycles_d = CNT_W'(sat_inc(32'(cycles_q), CNT_W));
              if (!en) state_d = IDLE;
            end
          end
        end
      end

      DONE, FAIL: begin
        if (!en) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign expected  = expected_q;
  assign mismatch  = mismatch_q;
  assign error     = error_q;
  assign err_count = err_count_q;
  assign laps      = laps_q;
  assign cycles    = cycles_q;
  assign busy      = (state_q == SYNC) || (state_q == TRACK);
  assign done      = (state_q == DONE);

endmodule
